// File: rtl/fb_readback_tx.sv
// fb_readback_tx: streams a finished frame buffer to the host over the UART
// byte interface. It sends a 4-byte little-endian pixel count, then each pixel
// as 3 bytes, LSB first. It owns the frame-buffer read port while busy.
module fb_readback_tx #(
  parameter int NUM_PIXELS = 307200,
  parameter int ADDR_W     = 21,
  parameter int PIX_W      = 24,
  parameter int RD_LAT     = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              transmit_en,
  input  logic [PIX_W-1:0]  pixel_rgb,
  input  logic              tx_done,
  output logic              read_fb,
  output logic [ADDR_W-1:0] fb_addr,
  output logic              trmt,
  output logic [7:0]        tx_data,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_FETCH,
    S_RDWAIT,
    S_SEND,
    S_FIN,
    S_DRAIN
  } state_t;

  localparam logic [31:0]       HDR_WORD = 32'(NUM_PIXELS);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_PIXELS - 1);
  localparam logic [1:0]        LAT_MAX  = 2'(RD_LAT);

  state_t             r_state,    w_state;
  logic               r_busy,     w_busy;
  logic [ADDR_W-1:0]  r_fb_addr,  w_fb_addr;
  logic               r_trmt,     w_trmt;
  logic [7:0]         r_tx_data,  w_tx_data;
  logic               r_done,     w_done;
  logic [ADDR_W-1:0]  r_idx,      w_idx;
  logic [1:0]         r_byte_cnt, w_byte_cnt;
  logic               r_inflight, w_inflight;
  logic [1:0]         r_gap,      w_gap;
  logic [1:0]         r_lat,      w_lat;
  logic [PIX_W-1:0]   r_shift,    w_shift;

  logic               w_byte_ok;
  logic               w_abort;
  logic [1:0]         w_nxt_cnt;

  // State and output registers; every output is registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_busy     <= 1'b0;
      r_fb_addr  <= '0;
      r_trmt     <= 1'b0;
      r_tx_data  <= '0;
      r_done     <= 1'b0;
      r_idx      <= '0;
      r_byte_cnt <= '0;
      r_inflight <= 1'b0;
      r_gap      <= '0;
      r_lat      <= '0;
      r_shift    <= '0;
    end else begin
      r_state    <= w_state;
      r_busy     <= w_busy;
      r_fb_addr  <= w_fb_addr;
      r_trmt     <= w_trmt;
      r_tx_data  <= w_tx_data;
      r_done     <= w_done;
      r_idx      <= w_idx;
      r_byte_cnt <= w_byte_cnt;
      r_inflight <= w_inflight;
      r_gap      <= w_gap;
      r_lat      <= w_lat;
      r_shift    <= w_shift;
    end
  end

  // Next-state logic: byte handshake, pixel fetch/latch, frame sequencing, abort.
  always_comb begin
    w_state    = r_state;
    w_busy     = r_busy;
    w_fb_addr  = r_fb_addr;
    w_trmt     = 1'b0;
    w_tx_data  = r_tx_data;
    w_done     = 1'b0;
    w_idx      = r_idx;
    w_byte_cnt = r_byte_cnt;
    w_inflight = r_inflight;
    w_gap      = r_gap;
    w_lat      = r_lat;
    w_shift    = r_shift;
    w_nxt_cnt  = r_byte_cnt + 2'd1;

    // tx_done is ignored for two cycles after trmt, since the UART may still
    // be showing the previous byte's done level.
    w_byte_ok = r_inflight && (r_gap == 2'd0) && tx_done;
    if (r_inflight && (r_gap != 2'd0)) begin
      w_gap = r_gap - 2'd1;
    end

    w_abort = !transmit_en &&
              ((r_state == S_HDR) || (r_state == S_FETCH) ||
               (r_state == S_RDWAIT) || (r_state == S_SEND));

    case (r_state)
      S_IDLE: begin
        if (start && transmit_en) begin
          w_state    = S_HDR;
          w_busy     = 1'b1;
          w_idx      = '0;
          w_byte_cnt = '0;
          w_inflight = 1'b0;
        end
      end

      S_HDR: begin
        if (w_abort) begin
          w_state = S_DRAIN;
        end else if (!r_inflight) begin
          w_trmt     = 1'b1;
          w_tx_data  = HDR_WORD[{r_byte_cnt, 3'b000} +: 8];
          w_inflight = 1'b1;
          w_gap      = 2'd2;
        end else if (w_byte_ok) begin
          if (r_byte_cnt == 2'd3) begin
            w_state    = S_FETCH;
            w_byte_cnt = '0;
            w_inflight = 1'b0;
          end else begin
            // Next byte goes out the cycle right after completion.
            w_byte_cnt = w_nxt_cnt;
            w_trmt     = 1'b1;
            w_tx_data  = HDR_WORD[{w_nxt_cnt, 3'b000} +: 8];
            w_gap      = 2'd2;
          end
        end
      end

      S_FETCH: begin
        if (w_abort) begin
          w_state = S_DRAIN;
        end else begin
          w_fb_addr = r_idx;
          w_lat     = '0;
          w_state   = S_RDWAIT;
        end
      end

      S_RDWAIT: begin
        if (w_abort) begin
          w_state = S_DRAIN;
        end else if (r_lat == LAT_MAX) begin
          w_shift    = pixel_rgb;
          w_state    = S_SEND;
          w_byte_cnt = '0;
          w_inflight = 1'b0;
        end else begin
          w_lat = r_lat + 2'd1;
        end
      end

      S_SEND: begin
        if (w_abort) begin
          w_state = S_DRAIN;
        end else if (!r_inflight) begin
          w_trmt     = 1'b1;
          w_tx_data  = r_shift[7:0];
          w_shift    = r_shift >> 8;
          w_inflight = 1'b1;
          w_gap      = 2'd2;
        end else if (w_byte_ok) begin
          if (r_byte_cnt == 2'd2) begin
            w_inflight = 1'b0;
            w_byte_cnt = '0;
            if (r_idx == LAST_IDX) begin
              w_state = S_FIN;
              w_done  = 1'b1;
            end else begin
              w_idx   = r_idx + ADDR_W'(1);
              w_state = S_FETCH;
            end
          end else begin
            w_byte_cnt = w_nxt_cnt;
            w_trmt     = 1'b1;
            w_tx_data  = r_shift[7:0];
            w_shift    = r_shift >> 8;
            w_gap      = 2'd2;
          end
        end
      end

      S_FIN: begin
        w_state   = S_IDLE;
        w_busy    = 1'b0;
        w_fb_addr = '0;
        w_idx     = '0;
      end

      S_DRAIN: begin
        if (!r_inflight || w_byte_ok) begin
          w_state    = S_IDLE;
          w_busy     = 1'b0;
          w_inflight = 1'b0;
          w_byte_cnt = '0;
          w_fb_addr  = '0;
          w_idx      = '0;
        end
      end

      default: begin
        w_state = S_IDLE;
        w_busy  = 1'b0;
      end
    endcase
  end

  assign read_fb = r_busy;
  assign busy    = r_busy;
  assign fb_addr = r_fb_addr;
  assign trmt    = r_trmt;
  assign tx_data = r_tx_data;
  assign done    = r_done;

endmodule

// File: tb/tb_fb_readback_tx.sv
// Directed bench for fb_readback_tx with NUM_PIXELS=2 and RD_LAT=2. A UART
// responder records every byte sent and flags protocol or stability errors;
// a pipelined memory model supplies pixel_rgb.
module tb_fb_readback_tx;

  localparam int ADDR_W = 4;
  localparam int PIX_W  = 24;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              transmit_en = 1'b1;
  logic [PIX_W-1:0]  pixel_rgb;
  logic              tx_done = 1'b1;
  logic              read_fb;
  logic [ADDR_W-1:0] fb_addr;
  logic              trmt;
  logic [7:0]        tx_data;
  logic              busy;
  logic              done;

  int n_checks = 0;
  int n_fail   = 0;

  fb_readback_tx #(
    .NUM_PIXELS(2),
    .ADDR_W(ADDR_W),
    .PIX_W(PIX_W),
    .RD_LAT(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .transmit_en(transmit_en),
    .pixel_rgb(pixel_rgb),
    .tx_done(tx_done),
    .read_fb(read_fb),
    .fb_addr(fb_addr),
    .trmt(trmt),
    .tx_data(tx_data),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  // Frame buffer with a two-stage registered read path.
  logic [PIX_W-1:0] mem [0:15];
  logic [PIX_W-1:0] p0, p1;
  always @(posedge clk) begin
    p0 <= mem[fb_addr];
    p1 <= p0;
  end
  assign pixel_rgb = p1;

  // UART responder, evaluated on the falling edge.
  logic [7:0] rx [0:255];
  int rx_n   = 0;
  int done_n = 0;
  int viol   = 0;
  int cnt    = 0;
  int dly    = 3;
  logic [7:0] last_d = 8'h00;
  always @(negedge clk) begin
    if (reset) begin
      tx_done = 1'b1;
      cnt     = 0;
      last_d  = 8'h00;
    end else begin
      if (trmt) begin
        if (!tx_done || cnt != 0) viol++;
        if (rx_n < 256) rx[rx_n] = tx_data;
        rx_n++;
        last_d  = tx_data;
        tx_done = 1'b0;
        cnt     = dly;
      end else begin
        if (tx_data !== last_d) viol++;
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) tx_done = 1'b1;
        end
      end
      if (done) done_n++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_rx(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (rx_n >= n) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_checks++; if (trmt !== 1'b0) begin n_fail++; $display("FAIL reset_trmt got %b want 0", trmt); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (read_fb !== 1'b0) begin n_fail++; $display("FAIL reset_read_fb got %b want 0", read_fb); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_checks++; if (fb_addr !== 4'h0) begin n_fail++; $display("FAIL reset_fb_addr got %h want 0", fb_addr); end
    n_checks++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data got %h want 00", tx_data); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_frame();
    logic [7:0] exp [0:9];
    int b, v, d;
    bit ok;
    exp = '{8'h02, 8'h00, 8'h00, 8'h00, 8'hC3, 8'hB2, 8'hA1, 8'h33, 8'h22, 8'h11};
    mem[0] = 24'hA1B2C3;
    mem[1] = 24'h112233;
    dly = 3;
    b = rx_n; v = viol; d = done_n;
    pulse_start();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL frame_busy_rise got %b want 1", busy); end
    n_checks++; if (read_fb !== 1'b1) begin n_fail++; $display("FAIL frame_read_fb got %b want 1", read_fb); end
    wait_idle(500, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL frame_timeout busy got %b want 0", busy); end
    tick();
    n_checks++; if (rx_n - b !== 10) begin n_fail++; $display("FAIL frame_count got %0d want 10", rx_n - b); end
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (rx[b + i] !== exp[i]) begin n_fail++; $display("FAIL frame_byte%0d got %h want %h", i, rx[b + i], exp[i]); end
    end
    n_checks++; if (done_n - d !== 1) begin n_fail++; $display("FAIL frame_done got %0d want 1", done_n - d); end
    n_checks++; if (viol - v !== 0) begin n_fail++; $display("FAIL frame_protocol got %0d want 0", viol - v); end
    n_checks++; if (fb_addr !== 4'h0) begin n_fail++; $display("FAIL frame_fb_addr got %h want 0", fb_addr); end
  endtask

  task automatic test_latch();
    logic [7:0] exp [0:9];
    int b, d;
    bit ok;
    exp = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h01, 8'hAD, 8'hDE, 8'h33, 8'h22, 8'h11};
    mem[0] = 24'hDEAD01;
    mem[1] = 24'h112233;
    b = rx_n; d = done_n;
    pulse_start();
    wait_rx(b + 5, 500, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL latch_timeout got %0d bytes want 5", rx_n - b); end
    mem[0] = 24'h000000;
    wait_idle(500, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL latch_idle_timeout busy got %b want 0", busy); end
    tick();
    n_checks++; if (rx_n - b !== 10) begin n_fail++; $display("FAIL latch_count got %0d want 10", rx_n - b); end
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (rx[b + i] !== exp[i]) begin n_fail++; $display("FAIL latch_byte%0d got %h want %h", i, rx[b + i], exp[i]); end
    end
    n_checks++; if (done_n - d !== 1) begin n_fail++; $display("FAIL latch_done got %0d want 1", done_n - d); end
  endtask

  task automatic test_start_ignored();
    int b, d, k;
    bit ok;
    mem[0] = 24'hA1B2C3;
    mem[1] = 24'h112233;
    b = rx_n; d = done_n;
    pulse_start();
    ok = 1'b0;
    k = 0;
    for (int i = 0; i < 500; i++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      k++;
      start = (k % 7 == 0);
      tick();
    end
    start = 1'b0;
    n_checks++; if (!ok) begin n_fail++; $display("FAIL b2b_timeout busy got %b want 0", busy); end
    for (int i = 0; i < 40; i++) tick();
    n_checks++; if (rx_n - b !== 10) begin n_fail++; $display("FAIL b2b_count got %0d want 10", rx_n - b); end
    n_checks++; if (done_n - d !== 1) begin n_fail++; $display("FAIL b2b_done got %0d want 1", done_n - d); end
    n_checks++; if (rx[b + 9] !== 8'h11) begin n_fail++; $display("FAIL b2b_last got %h want 11", rx[b + 9]); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_restart busy got %b want 0", busy); end
  endtask

  task automatic test_abort();
    int b, d;
    bit ok;
    mem[0] = 24'hA1B2C3;
    mem[1] = 24'h112233;
    dly = 20;
    b = rx_n; d = done_n;
    pulse_start();
    wait_rx(b + 6, 1000, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL abort_timeout got %0d bytes want 6", rx_n - b); end
    transmit_en = 1'b0;
    tick(); tick(); tick();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_inflight_busy got %b want 1", busy); end
    wait_idle(100, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL abort_idle_timeout busy got %b want 0", busy); end
    n_checks++; if (tx_done !== 1'b1) begin n_fail++; $display("FAIL abort_early_exit tx_done got %b want 1", tx_done); end
    for (int i = 0; i < 60; i++) tick();
    n_checks++; if (rx_n - b !== 6) begin n_fail++; $display("FAIL abort_count got %0d want 6", rx_n - b); end
    n_checks++; if (rx[b + 5] !== 8'hB2) begin n_fail++; $display("FAIL abort_last got %h want b2", rx[b + 5]); end
    n_checks++; if (done_n - d !== 0) begin n_fail++; $display("FAIL abort_done got %0d want 0", done_n - d); end
    n_checks++; if (read_fb !== 1'b0) begin n_fail++; $display("FAIL abort_read_fb got %b want 0", read_fb); end
    // start with the enable low must be dropped
    pulse_start();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL disabled_start busy got %b want 0", busy); end
    transmit_en = 1'b1;
    dly = 3;
    tick();
  endtask

  task automatic test_reset_mid();
    int b, d;
    bit ok;
    mem[0] = 24'hA1B2C3;
    mem[1] = 24'h112233;
    b = rx_n;
    pulse_start();
    wait_rx(b + 2, 500, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rstmid_timeout got %0d bytes want 2", rx_n - b); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++; if (trmt !== 1'b0) begin n_fail++; $display("FAIL rstmid_trmt got %b want 0", trmt); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %b want 0", busy); end
    n_checks++; if (read_fb !== 1'b0) begin n_fail++; $display("FAIL rstmid_read_fb got %b want 0", read_fb); end
    n_checks++; if (fb_addr !== 4'h0) begin n_fail++; $display("FAIL rstmid_fb_addr got %h want 0", fb_addr); end
    tick(); tick();
    b = rx_n; d = done_n;
    pulse_start();
    wait_idle(500, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rstmid_idle_timeout busy got %b want 0", busy); end
    tick();
    n_checks++; if (rx_n - b !== 10) begin n_fail++; $display("FAIL rstmid_count got %0d want 10", rx_n - b); end
    n_checks++; if (rx[b] !== 8'h02) begin n_fail++; $display("FAIL rstmid_first got %h want 02", rx[b]); end
    n_checks++; if (rx[b + 4] !== 8'hC3) begin n_fail++; $display("FAIL rstmid_pix got %h want c3", rx[b + 4]); end
    n_checks++; if (done_n - d !== 1) begin n_fail++; $display("FAIL rstmid_done got %0d want 1", done_n - d); end
  endtask

  task automatic test_slow_uart();
    int b, v;
    bit ok;
    mem[0] = 24'h5A6B7C;
    mem[1] = 24'h0F1E2D;
    dly = 10000;
    b = rx_n; v = viol;
    pulse_start();
    wait_rx(b + 2, 12000, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL slow_timeout got %0d bytes want 2", rx_n - b); end
    dly = 3;
    wait_idle(12000, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL slow_idle_timeout busy got %b want 0", busy); end
    tick();
    n_checks++; if (viol - v !== 0) begin n_fail++; $display("FAIL slow_protocol got %0d want 0", viol - v); end
    n_checks++; if (rx_n - b !== 10) begin n_fail++; $display("FAIL slow_count got %0d want 10", rx_n - b); end
    n_checks++; if (rx[b + 1] !== 8'h00) begin n_fail++; $display("FAIL slow_byte1 got %h want 00", rx[b + 1]); end
    n_checks++; if (rx[b + 6] !== 8'h5A) begin n_fail++; $display("FAIL slow_byte6 got %h want 5a", rx[b + 6]); end
    n_checks++; if (rx[b + 7] !== 8'h2D) begin n_fail++; $display("FAIL slow_byte7 got %h want 2d", rx[b + 7]); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    test_reset();
    test_frame();
    test_latch();
    test_start_ignored();
    test_abort();
    test_reset_mid();
    test_slow_uart();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
